// File: rtl/barrido_pkg.sv
// Shared types and constants for the barrido_eje7 16-vector exhaustive sweep.
package barrido_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int unsigned NUM_VEC  = 16;
    localparam int unsigned LAST_VEC = 15;
    localparam logic [2:0]  XYZ_HOLD = 3'b111;

    localparam int unsigned PAIR_Y  = 0;
    localparam int unsigned PAIR_Z  = 1;
    localparam int unsigned PAIR_F2 = 2;

    // 3-input stimulus follows the low bits of n, then parks at all-ones
    function automatic logic [2:0] xyz_of(input logic [3:0] n);
        return n[3] ? XYZ_HOLD : n[2:0];
    endfunction

endpackage

// File: rtl/barrido_eje7_comparador_pares.sv
// Pairwise response comparator: flags each function whose two implementations disagree.
import barrido_pkg::*;

module comparador_pares (
    input  logic [5:0] i_resp,   // {Y, Y_2, Z, Z_2, F2, F2_2}
    output logic [2:0] o_mis
);

    // One XOR per pair; bit positions follow the pair index constants
    always_comb begin
        o_mis          = '0;
        o_mis[PAIR_Y]  = i_resp[5] ^ i_resp[4];
        o_mis[PAIR_Z]  = i_resp[3] ^ i_resp[2];
        o_mis[PAIR_F2] = i_resp[1] ^ i_resp[0];
    end

endmodule

// File: rtl/barrido_eje7.sv
// barrido_eje7: drives all 16 input vectors into a downstream function block,
// waits SETTLE_CYC cycles per vector, then compares three response pairs.
// Optional response log enabled by defining BARRIDO_LOG_EN.
import barrido_pkg::*;

module barrido_eje7 #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       Y,
    input  logic       Y_2,
    input  logic       Z,
    input  logic       Z_2,
    input  logic       F2,
    input  logic       F2_2,
    output logic       busy,
    output logic       done,
    output logic [2:0] err_flags,
    output logic [4:0] err_cnt,
    output logic [3:0] first_err,
    output logic       first_err_vld,
    input  logic [3:0] rd_addr,
    output logic [5:0] rd_data
);

    localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] N_LAST    = 4'(LAST_VEC);
    localparam logic [4:0] CNT_MAX   = 5'(NUM_VEC);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_n;
    logic [3:0] r_wait;
    logic [3:0] r_abcd;
    logic [2:0] r_xyz;
    logic       r_busy;
    logic       r_done;
    logic [2:0] r_err_flags;
    logic [4:0] r_err_cnt;
    logic [3:0] r_first_err;
    logic       r_first_vld;
    logic       w_accept;
    logic [5:0] w_resp;
    logic [2:0] w_mis;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_resp   = {Y, Y_2, Z, Z_2, F2, F2_2};

    comparador_pares u_cmp (
        .i_resp (w_resp),
        .o_mis  (w_mis)
    );

    // State register; reset wins over any start at the same edge
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_accept) w_next = ST_DRIVE;
            ST_DRIVE:         w_next = ST_SETTLE;
            ST_SETTLE:        if (r_wait == WAIT_LAST) w_next = ST_SAMPLE;
            ST_SAMPLE:        w_next = (r_n == N_LAST) ? ST_DONE : ST_DRIVE;
            default:          w_next = ST_IDLE;
        endcase
    end

    // Vector index, settle counter, stimulus and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_n         <= '0;
            r_wait      <= '0;
            r_abcd      <= '0;
            r_xyz       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_flags <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_first_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_n         <= '0;
                        r_err_flags <= '0;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        r_first_vld <= 1'b0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    r_abcd <= r_n;
                    r_xyz  <= xyz_of(r_n);
                    r_wait <= '0;
                end
                ST_SETTLE: begin
                    r_wait <= r_wait + 4'd1;
                end
                ST_SAMPLE: begin
                    if (|w_mis) begin
                        r_err_flags <= r_err_flags | w_mis;
                        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 5'd1;
                        if (!r_first_vld) begin
                            r_first_err <= r_n;
                            r_first_vld <= 1'b1;
                        end
                    end
                    if (r_n == N_LAST) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_n <= r_n + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {A, B, C, D} = r_abcd;
    assign {x, y, z}    = r_xyz;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_flags     = r_err_flags;
    assign err_cnt       = r_err_cnt;
    assign first_err     = r_first_err;
    assign first_err_vld = r_first_vld;

`ifdef BARRIDO_LOG_EN
    logic [5:0] r_log [NUM_VEC];

    // Response log, one entry per vector; intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (reset_n && (r_state == ST_SAMPLE)) r_log[r_n] <= w_resp;
    end

    assign rd_data = r_log[rd_addr];
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^rd_addr;
    assign rd_data          = '0;
`endif

endmodule

// File: tb/tb_barrido_eje7.sv
// Self-checking bench for barrido_eje7 (SETTLE_CYC=3); responses come from
// per-vector base/mismatch tables, expectations from a set-level model.
module tb_barrido_eje7;

    localparam int unsigned SC    = 3;
    localparam int          SWEEP = 16 * (SC + 2);

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       A, B, C, D, x, y, z;
    logic       Y, Y_2, Z, Z_2, F2, F2_2;
    logic       busy, done, first_err_vld;
    logic [2:0] err_flags;
    logic [4:0] err_cnt;
    logic [3:0] first_err;
    logic [3:0] rd_addr;
    logic [5:0] rd_data;

    logic [2:0] base_t [16];
    logic [2:0] mask_t [16];
    logic [3:0] w_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    barrido_eje7 #(.SETTLE_CYC(SC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .A(A), .B(B), .C(C), .D(D), .x(x), .y(y), .z(z),
        .Y(Y), .Y_2(Y_2), .Z(Z), .Z_2(Z_2), .F2(F2), .F2_2(F2_2),
        .busy(busy), .done(done), .err_flags(err_flags), .err_cnt(err_cnt),
        .first_err(first_err), .first_err_vld(first_err_vld),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Downstream function block stand-in: reacts to the applied vector
    assign w_idx = {A, B, C, D};
    always_comb begin
        Y    = base_t[w_idx][0];
        Y_2  = base_t[w_idx][0] ^ mask_t[w_idx][0];
        Z    = base_t[w_idx][1];
        Z_2  = base_t[w_idx][1] ^ mask_t[w_idx][1];
        F2   = base_t[w_idx][2];
        F2_2 = base_t[w_idx][2] ^ mask_t[w_idx][2];
    end

    function automatic logic [5:0] log_exp(input logic [3:0] a);
`ifdef BARRIDO_LOG_EN
        return {base_t[a][0], base_t[a][0] ^ mask_t[a][0],
                base_t[a][1], base_t[a][1] ^ mask_t[a][1],
                base_t[a][2], base_t[a][2] ^ mask_t[a][2]};
`else
        return 6'b0;
`endif
    endfunction

    task automatic fill_tables(input int mode);
        for (int i = 0; i < 16; i++) begin
            base_t[i] = 3'($urandom);
            case (mode)
                0: mask_t[i] = 3'b000;
                1: mask_t[i] = 3'b111;
                default: mask_t[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            endcase
        end
    endtask

    task automatic run_sweep(input string tag, input int inject, input int stop_at);
        logic [3:0] en;
        logic [2:0] ex;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, done, err_flags, err_cnt, first_err_vld} !== {1'b1, 1'b0, 3'b0, 5'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_accept got busy=%b done=%b flags=%b cnt=%0d vld=%b exp busy=1 done=0 cleared",
                     tag, busy, done, err_flags, err_cnt, first_err_vld);
        end
        for (int k = 1; k <= stop_at; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            en = 4'((k - 1) / (SC + 2));
            ex = (en >= 4'd8) ? 3'b111 : en[2:0];
            checks++;
            if ({A, B, C, D, x, y, z} !== {en, ex}) begin
                errors++;
                $display("FAIL %s_stim cyc=%0d got abcd=%h xyz=%b exp abcd=%h xyz=%b",
                         tag, k, {A, B, C, D}, {x, y, z}, en, ex);
            end
            checks++;
            if ({busy, done} !== {k < SWEEP, k >= SWEEP}) begin
                errors++;
                $display("FAIL %s_timing cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                         tag, k, busy, done, k < SWEEP, k >= SWEEP);
            end
            if (k == inject) start = 1'b1;
        end
    endtask

    task automatic check_results(input string tag);
        logic [2:0] ef;
        logic [4:0] ec;
        logic [3:0] fe;
        logic       fv;
        logic [3:0] a;
        ef = '0; ec = '0; fe = '0; fv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (mask_t[i] != 3'b000) begin
                ef = ef | mask_t[i];
                ec = ec + 5'd1;
                if (!fv) begin fv = 1'b1; fe = 4'(i); end
            end
        end
        checks++;
        if ({err_flags, err_cnt, first_err_vld} !== {ef, ec, fv}) begin
            errors++;
            $display("FAIL %s_errs got flags=%b cnt=%0d vld=%b exp flags=%b cnt=%0d vld=%b",
                     tag, err_flags, err_cnt, first_err_vld, ef, ec, fv);
        end
        if (fv) begin
            checks++;
            if (first_err !== fe) begin
                errors++;
                $display("FAIL %s_first got %0d exp %0d", tag, first_err, fe);
            end
        end
        for (int j = 0; j < 2; j++) begin
            a = (j == 0) ? 4'd9 : 4'($urandom);
            rd_addr = a; #1;
            checks++;
            if (rd_data !== log_exp(a)) begin
                errors++;
                $display("FAIL %s_rd addr=%0d got %b exp %b", tag, a, rd_data, log_exp(a));
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({A, B, C, D, x, y, z, busy, done, err_flags, err_cnt, first_err, first_err_vld} !== 22'b0) begin
            errors++;
            $display("FAIL reset_vals got %b exp 0",
                     {A, B, C, D, x, y, z, busy, done, err_flags, err_cnt, first_err, first_err_vld});
        end
`ifndef BARRIDO_LOG_EN
        checks++;
        if (rd_data !== 6'b0) begin
            errors++;
            $display("FAIL reset_rd got %b exp 0", rd_data);
        end
`endif
        start = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b exp 00", busy, done);
        end
    endtask

    task automatic test_clean();
        fill_tables(0);
        run_sweep("clean", -1, SWEEP);
        check_results("clean");
    endtask

    task automatic test_z_flip();
        fill_tables(0);
        mask_t[5]  = 3'b010;
        mask_t[12] = 3'b010;
        run_sweep("zflip", -1, SWEEP);
        check_results("zflip");
    endtask

    task automatic test_all_diff();
        fill_tables(1);
        run_sweep("alldiff", 10, SWEEP);
        check_results("alldiff");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_tables(2);
            run_sweep("rand", -1, SWEEP);
            check_results("rand");
        end
    endtask

    task automatic test_done_hold();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({done, busy, A, B, C, D, x, y, z} !== {1'b1, 1'b0, 4'hF, 3'b111}) begin
            errors++;
            $display("FAIL done_hold got done=%b busy=%b abcd=%h xyz=%b exp 1 0 F 111",
                     done, busy, {A, B, C, D}, {x, y, z});
        end
    endtask

    task automatic test_mid_reset();
        fill_tables(1);
        run_sweep("midrst", -1, 20);
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({A, B, C, D, x, y, z, busy, done, err_flags, err_cnt, first_err, first_err_vld} !== 22'b0) begin
            errors++;
            $display("FAIL midrst_vals got %b exp 0",
                     {A, B, C, D, x, y, z, busy, done, err_flags, err_cnt, first_err, first_err_vld});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        fill_tables(2);
        run_sweep("fresh", -1, SWEEP);
        check_results("fresh");
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        rd_addr = '0;
        fill_tables(0);
        test_reset();
        test_clean();
        test_done_hold();
        test_z_flip();
        test_all_diff();
        test_random();
        test_mid_reset();
        test_done_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
